// File: rtl/lfsr_key_search.sv
// lfsr_key_search: recovers the LFSR tap pattern and seed from the space
// preamble of a ciphertext. It loads CHECK_LEN bytes from data memory, then
// tries each legal 7-bit maximal-length tap pattern in table order.
module lfsr_key_search #(
  parameter logic [7:0]  BASE_ADDR = 8'd64,
  parameter int unsigned CHECK_LEN = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic [7:0] RdAddr,
  input  logic [7:0] RdData,
  output logic       Ack,
  output logic       Found,
  output logic [3:0] PtrnIdx,
  output logic [6:0] Ptrn,
  output logic [6:0] Seed,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;

  localparam logic [3:0] LAST    = 4'(CHECK_LEN - 1);
  localparam logic [3:0] LAST_PT = 4'd8;

  state_t     state, state_n;
  logic [3:0] idx;                  // load index
  logic [3:0] p;                    // tap table index under test
  logic [3:0] k;                    // preamble byte being predicted
  logic [6:0] s;                    // current LFSR state
  logic [6:0] cbuf [CHECK_LEN];
  logic [6:0] tap;
  logic [6:0] n;
  logic       hit;
  logic       unused_parity;

  // Bit 7 of each byte is an optional parity bit and carries no key material.
  assign unused_parity = RdData[7];

  function automatic logic [6:0] tap_of(input logic [3:0] i);
    case (i)
      4'd0:    return 7'h60;
      4'd1:    return 7'h48;
      4'd2:    return 7'h78;
      4'd3:    return 7'h72;
      4'd4:    return 7'h6A;
      4'd5:    return 7'h69;
      4'd6:    return 7'h5C;
      4'd7:    return 7'h7E;
      4'd8:    return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  // One LFSR step under the current candidate pattern and its comparison.
  always_comb begin
    tap = tap_of(p);
    n   = {s[5:0], ^(s & tap)};
    hit = (n == cbuf[k]);
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    Busy   = (state == LOAD) || (state == SEARCH);
    RdAddr = (state == LOAD) ? BASE_ADDR + {4'b0000, idx} : BASE_ADDR;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; Start high forces IDLE from every state.
  always_comb begin
    state_n = state;
    if (Start) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:   state_n = LOAD;
        LOAD:   if (idx == LAST) state_n = (cbuf[0] == '0) ? DONE : SEARCH;
        SEARCH: if ((hit && k == LAST) || (!hit && p == LAST_PT)) state_n = DONE;
        DONE:   state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Datapath: buffer load, pattern search and result registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Ack     <= 1'b0;
      Found   <= 1'b0;
      PtrnIdx <= '0;
      Ptrn    <= '0;
      Seed    <= '0;
      idx     <= '0;
      p       <= '0;
      k       <= '0;
      s       <= '0;
      for (int unsigned j = 0; j < CHECK_LEN; j++) cbuf[j] <= '0;
    end else begin
      Ack <= (state_n == DONE);
      if (!Start) begin
        case (state)
          IDLE: begin
            Found   <= 1'b0;
            PtrnIdx <= '0;
            Ptrn    <= '0;
            Seed    <= '0;
            idx     <= '0;
          end
          LOAD: begin
            cbuf[idx] <= RdData[6:0];
            idx       <= idx + 4'd1;
            if (idx == LAST) begin
              p <= '0;
              k <= 4'd1;
              s <= cbuf[0];
            end
          end
          SEARCH: begin
            if (hit) begin
              if (k == LAST) begin
                Found   <= 1'b1;
                PtrnIdx <= p;
                Ptrn    <= tap;
                Seed    <= cbuf[0];
              end else begin
                s <= n;
                k <= k + 4'd1;
              end
            end else if (p != LAST_PT) begin
              p <= p + 4'd1;
              k <= 4'd1;
              s <= cbuf[0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_key_search.sv
// Self-checking bench for lfsr_key_search with a sequence-level reference model.
module tb_lfsr_key_search;

  localparam int CL = 10;

  logic       Clk = 1'b0;
  logic       Reset, Start;
  logic [7:0] RdAddr, RdData;
  logic       Ack, Found, Busy;
  logic [3:0] PtrnIdx;
  logic [6:0] Ptrn, Seed;

  logic [7:0] mem [256];
  logic [6:0] pre [CL];
  int         total = 0;
  int         bad   = 0;
  int         taps [9] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};

  lfsr_key_search #(.BASE_ADDR(8'd64), .CHECK_LEN(CL)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .RdAddr(RdAddr), .RdData(RdData),
    .Ack(Ack), .Found(Found), .PtrnIdx(PtrnIdx), .Ptrn(Ptrn), .Seed(Seed), .Busy(Busy)
  );

  assign RdData = mem[RdAddr];

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] lfsr_next(input logic [6:0] v, input logic [6:0] t);
    return {v[5:0], ^(v & t)};
  endfunction

  // Preamble produced by tap t from seed sd.
  task automatic gen(input logic [6:0] t, input logic [6:0] sd);
    pre[0] = sd;
    for (int i = 1; i < CL; i++) pre[i] = lfsr_next(pre[i-1], t);
  endtask

  // Copy the preamble into memory with bit 7 forced high or randomised.
  task automatic put(input bit force7);
    for (int i = 0; i < CL; i++)
      mem[64+i] = {force7 ? 1'b1 : 1'($urandom), pre[i]};
  endtask

  // Reference: first pattern whose sequence reproduces the whole preamble,
  // and the total number of prediction steps spent finding it.
  task automatic model(output bit f, output int ix, output int steps);
    logic [6:0] v;
    bit ok;
    f = 0; ix = 0; steps = 0;
    if (pre[0] != 0) begin
      for (int j = 0; j < 9 && !f; j++) begin
        v = pre[0];
        ok = 1;
        for (int i = 1; i < CL && ok; i++) begin
          v = lfsr_next(v, 7'(taps[j]));
          steps++;
          if (v != pre[i]) ok = 0;
        end
        if (ok) begin f = 1; ix = j; end
      end
    end
  endtask

  task automatic run(input string tag, output int ack_cyc);
    bit f; int ix, steps, cnt;
    model(f, ix, steps);
    Start = 1'b1;
    repeat (2) @(negedge Clk);
    Start = 1'b0;
    cnt = 0;
    do begin
      @(posedge Clk); #1;
      cnt++;
      if (!Ack) begin
        chk({tag, "/busy"}, 32'(Busy), 32'd1);
        if (cnt <= CL) chk({tag, "/rdaddr"}, 32'(RdAddr), 32'(64 + cnt - 1));
      end
    end while (!Ack && cnt < 200);
    ack_cyc = cnt;
    chk({tag, "/ack_cycle"}, 32'(cnt), 32'(CL + steps + 1));
    chk({tag, "/busy_done"}, 32'(Busy), 32'd0);
    chk({tag, "/rdaddr_done"}, 32'(RdAddr), 32'd64);
    chk({tag, "/found"}, 32'(Found), 32'(f));
    chk({tag, "/idx"}, 32'(PtrnIdx), f ? 32'(ix) : 32'd0);
    chk({tag, "/ptrn"}, 32'(Ptrn), f ? 32'(taps[ix]) : 32'd0);
    chk({tag, "/seed"}, 32'(Seed), f ? 32'(pre[0]) : 32'd0);
    @(posedge Clk); #1;
    chk({tag, "/ack_hold"}, 32'(Ack), 32'd1);
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk); #1;
    chk({tag, "/ack_clear"}, 32'(Ack), 32'd0);
    chk({tag, "/found_kept"}, 32'(Found), 32'(f));
    chk({tag, "/idx_kept"}, 32'(PtrnIdx), f ? 32'(ix) : 32'd0);
  endtask

  task automatic set_example();
    logic [6:0] ex [CL] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h11, 7'h22, 7'h44, 7'h09, 7'h13, 7'h26};
    for (int i = 0; i < CL; i++) pre[i] = ex[i];
  endtask

  initial begin
    int ac, cnt;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    Reset = 1'b1;
    Start = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst/ack", 32'(Ack), 32'd0);
    chk("rst/found", 32'(Found), 32'd0);
    chk("rst/busy", 32'(Busy), 32'd0);
    chk("rst/rdaddr", 32'(RdAddr), 32'd64);
    chk("rst/seed", 32'(Seed), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    set_example(); put(0);
    run("example", ac);
    chk("example/cycle24", 32'(ac), 32'd24);
    chk("example/idx1", 32'(PtrnIdx), 32'd1);
    chk("example/ptrn48", 32'(Ptrn), 32'h48);

    put(1);
    run("parity", ac);
    chk("parity/cycle24", 32'(ac), 32'd24);

    for (int i = 0; i < CL; i++) pre[i] = 7'h00;
    put(0);
    run("zero", ac);
    chk("zero/cycle11", 32'(ac), 32'd11);

    pre[0] = 7'h01;
    for (int i = 1; i < CL; i++) pre[i] = 7'h7F;
    put(0);
    run("nomatch", ac);
    chk("nomatch/found0", 32'(Found), 32'd0);
    chk("nomatch/le92", 32'(ac <= 92), 32'd1);

    for (int j = 0; j < 9; j++) begin
      for (int r = 0; r < 3; r++) begin
        logic [6:0] sd;
        sd = (j == 8 && r == 0) ? 7'h5A : 7'($urandom_range(1, 127));
        gen(7'(taps[j]), sd);
        put(0);
        run($sformatf("gen_t%0d_s%0h", j, sd), ac);
        if (j == 8 && r == 0) begin
          chk("gen7b/idx8", 32'(PtrnIdx), 32'd8);
          chk("gen7b/seed5a", 32'(Seed), 32'h5A);
        end
      end
    end

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < CL; i++) pre[i] = 7'($urandom);
      put(0);
      run($sformatf("rand%0d", r), ac);
    end

    // Abort during SEARCH.
    set_example(); put(0);
    Start = 1'b1;
    repeat (2) @(negedge Clk);
    Start = 1'b0;
    cnt = 0;
    while (cnt < 12) begin @(posedge Clk); #1; cnt++; end
    chk("abort/busy_before", 32'(Busy), 32'd1);
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk); #1;
    chk("abort/ack", 32'(Ack), 32'd0);
    chk("abort/found", 32'(Found), 32'd0);
    chk("abort/busy", 32'(Busy), 32'd0);
    chk("abort/idx", 32'(PtrnIdx), 32'd0);

    // Reset during LOAD.
    @(negedge Clk);
    Start = 1'b0;
    cnt = 0;
    while (cnt < 3) begin @(posedge Clk); #1; cnt++; end
    chk("rstload/busy_before", 32'(Busy), 32'd1);
    @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b1;
    @(posedge Clk); #1;
    chk("rstload/ack", 32'(Ack), 32'd0);
    chk("rstload/found", 32'(Found), 32'd0);
    chk("rstload/busy", 32'(Busy), 32'd0);
    chk("rstload/rdaddr", 32'(RdAddr), 32'd64);
    chk("rstload/ptrn", 32'(Ptrn), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    run("rerun", ac);
    chk("rerun/cycle24", 32'(ac), 32'd24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_key_search.md
# lfsr_key_search

Hardware key-recovery stage that sits directly upstream of the message decrypt program. It reads the first ciphertext bytes from data memory and exploits the guaranteed space-character preamble, whose plaintext after subtracting 0x20 is 0x00. From these it determines which of the 9 legal 7-bit maximal-length LFSR tap patterns was used, and the LFSR starting state. The decrypt stage consumes Ptrn/Seed instead of recomputing them in software.

## Interface
Parameters:
- BASE_ADDR, 8'd64: data-memory address of ciphertext byte 0.
- CHECK_LEN, 10: ciphertext bytes loaded and checked. Legal range 2..10, never more than the minimum preamble length.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; clears every register.
- Start  in  1  level. High = hold/abort; the run launches when Start is sampled low in IDLE.
- RdAddr  out  8  data-memory read address.
- RdData  in  8  data-memory read data; combinational (same-cycle) read of RdAddr.
- Ack  out  1  run complete; results valid.
- Found  out  1  a pattern matched all CHECK_LEN-1 steps.
- PtrnIdx  out  4  matching table index 0..8; 0 when !Found.
- Ptrn  out  7  matching tap pattern; 0 when !Found.
- Seed  out  7  recovered LFSR initial state; 0 when !Found.
- Busy  out  1  high in LOAD or SEARCH.

## Operation
- Tap table, fixed, index 0..8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- LFSR step: next = {s[5:0], ^(s & tap)}.
- Only bits [6:0] of RdData are used; bit 7 (optional parity) is ignored.
- States: IDLE, LOAD, SEARCH, DONE.
- IDLE:
  - Outputs held.
  - Start low → LOAD; on this transition clear Ack, Found, PtrnIdx, Ptrn, Seed and the load index.
- LOAD:
  - One byte per cycle: RdAddr = BASE_ADDR + i, i = 0..CHECK_LEN-1; buf[i] ← RdData[6:0].
  - After the last byte: if buf[0] == 0, go to DONE with Found = 0 (illegal seed). Otherwise go to SEARCH with p = 0, k = 1, s = buf[0].
- SEARCH, one step per cycle:
  - Compute n = step(s, tap[p]).
  - If n == buf[k] and k == CHECK_LEN-1 → DONE, Found = 1, PtrnIdx = p, Ptrn = tap[p], Seed = buf[0].
  - If n == buf[k] and k < CHECK_LEN-1 → s ← n, k ← k+1.
  - If n != buf[k] and p < 8 → p ← p+1, k ← 1, s ← buf[0].
  - If n != buf[k] and p == 8 → DONE, Found = 0.
- Lowest matching index wins.
- DONE: Ack = 1. Ack and results hold until Start is sampled high.
- Start high in any state → IDLE next cycle.
  - Ack clears.
  - From DONE, results are retained.
  - From LOAD or SEARCH the run aborts; results stay at the cleared values.
- Reset (any state) → IDLE. Ack, Found, PtrnIdx, Ptrn, Seed, Busy = 0; RdAddr = BASE_ADDR; buffers 0.

## Timing
- Run cycles are counted from the first LOAD cycle, cycle 1.
- LOAD takes exactly CHECK_LEN cycles.
- Each SEARCH cycle consumes one step. A mismatch costs 1 cycle and the next pattern starts the following cycle.
- Ack rises on the edge after the deciding cycle.
- Ack first high at cycle CHECK_LEN + (total SEARCH steps) + 1.
- Worst case (CHECK_LEN = 10): 10 + 81 + 1 = 92 cycles.
- Zero seed: Ack at cycle CHECK_LEN + 1, no SEARCH cycles.
- Busy is high exactly during LOAD and SEARCH cycles.
- RdAddr = BASE_ADDR outside LOAD.
- Ack is registered. Outputs change only on rising edges.

## Test plan
- Tap 0x48, seed 0x01, preamble ciphertext 0x01,02,04,08,11,22,44,09,13,26 at 64..73, Start falls:
  - Pattern 0 fails at step 4 (expects 0x10, sees 0x11).
  - Expect Found = 1, PtrnIdx = 1, Ptrn = 0x48, Seed = 0x01.
  - Ack first high at cycle 10 + 4 + 9 + 1 = 24.
- Same bytes with bit 7 set on every byte → identical results and timing.
- All ciphertext 0x00 → Found = 0, PtrnIdx/Ptrn/Seed = 0, Ack at cycle 11, no SEARCH cycles.
- Tap 0x7B, seed 0x5A, generated by a reference model → PtrnIdx = 8, Ptrn = 0x7B, Seed = 0x5A. Repeat for all 9 patterns × 3 seeds.
- Bytes matching no pattern (e.g., 0x01 followed by 0x7F ×9) → Found = 0, Ack ≤ cycle 92, Busy low from Ack onward.
- Abort: Start high during SEARCH → IDLE next cycle, Ack = 0, Found = 0. Reset mid-LOAD → all outputs 0, RdAddr = 64. A subsequent Start low reruns correctly.
